// File: rtl/vga_pkg.sv
// Purpose: shared raster geometry (800x600@60, 40 MHz pclk) and count types for the video chain.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package vga_pkg;

  localparam int CNT_W = 12;

  localparam int H_VISIBLE = 800;
  localparam int H_FRONT   = 40;
  localparam int H_SYNC    = 128;
  localparam int H_BACK    = 88;

  localparam int V_VISIBLE = 600;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 4;
  localparam int V_BACK    = 23;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef logic [CNT_W-1:0] cnt_t;

  // Total length of one axis (line or frame) from its four segments.
  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// Purpose: one raster axis counter with blanking/sync decode and a wrap strobe.
// Latency: count and flags are registered together, flags decoded from the next count (no skew).
// Backpressure: none; advances only when en && step, otherwise all state holds.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int VISIBLE = H_VISIBLE,
  parameter int FRONT   = H_FRONT,
  parameter int SYNC    = H_SYNC,
  parameter int BACK    = H_BACK,
  parameter bit POL     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic en,
  output cnt_t count,
  output logic blnk,
  output logic sync,
  output logic wrap
);

  localparam int   TOTAL    = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam int   SYNC_BEG = VISIBLE + FRONT;
  localparam int   SYNC_END = VISIBLE + FRONT + SYNC;
  localparam cnt_t LAST     = cnt_t'(TOTAL - 1);

  // The counter must be able to hold TOTAL-1.
  if (TOTAL > (1 << CNT_W)) begin : g_total_chk
    $error("vga_axis_cnt: axis total %0d exceeds %0d-bit counter", TOTAL, CNT_W);
  end

  logic adv;
  cnt_t count_nxt;
  logic blnk_nxt;
  logic sync_nxt;

  // Next count and flag decode; flags describe the value the counter is about to take.
  always_comb begin
    adv       = en & step;
    wrap      = adv && (count == LAST);
    count_nxt = count;
    if (wrap) begin
      count_nxt = '0;
    end else if (adv) begin
      count_nxt = count + cnt_t'(1);
    end
    blnk_nxt = (int'(count_nxt) >= VISIBLE);
    sync_nxt = ((int'(count_nxt) >= SYNC_BEG) && (int'(count_nxt) < SYNC_END)) ? POL : ~POL;
  end

  // Count and flags registered on the same edge so they stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= ~POL;
    end else begin
      count <= count_nxt;
      blnk  <= blnk_nxt;
      sync  <= sync_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: free-running VGA raster source: hcount/vcount, syncs, blanks and a frame_start pulse.
// Latency: all outputs registered, one coherent raster sample per pclk, no extra pipeline.
// Backpressure: none downstream; en low freezes every output and forces frame_start to 0.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic             frame_start
);

  logic hwrap;
  logic vwrap;

  vga_axis_cnt #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (HSYNC_POL)
  ) u_h_cnt (
    .clk   (pclk),
    .rst   (rst),
    .step  (en),
    .en    (en),
    .count (hcount_out),
    .blnk  (hblnk_out),
    .sync  (hsync_out),
    .wrap  (hwrap)
  );

  // Vertical axis advances only on the cycle the line wraps.
  vga_axis_cnt #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (VSYNC_POL)
  ) u_v_cnt (
    .clk   (pclk),
    .rst   (rst),
    .step  (hwrap),
    .en    (en),
    .count (vcount_out),
    .blnk  (vblnk_out),
    .sync  (vsync_out),
    .wrap  (vwrap)
  );

  // Pulse only when a counting edge lands on (0,0); the post-reset (0,0) is never flagged.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= hwrap & vwrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (25 x 12) so several frames fit in a short run.
// Two instances share stimulus: one with active-high syncs, one with active-low syncs.
// Expected samples come from a linear-position model and are checked by a separate monitor.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 4;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;   // 25
  localparam int VT = VV + VF + VS + VB;   // 12
  localparam int FT = HT * VT;             // 300

  typedef struct packed {
    logic [11:0] hc;
    logic [11:0] vc;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic        fs;
  } obs_t;

  logic        pclk = 1'b0;
  logic        rst;
  logic        en;

  logic [11:0] a_hc, a_vc, b_hc, b_vc;
  logic        a_hs, a_hb, a_vs, a_vb, a_fs;
  logic        b_hs, b_hb, b_vs, b_vb, b_fs;

  obs_t q[$];
  int   pos;
  bit   fs_m;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_fs = -1;
  bit   gap_chk = 1'b0;
  obs_t mon_e, mon_eb, mon_a, mon_b;

  always #5 pclk = ~pclk;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_a (
    .pclk(pclk), .rst(rst), .en(en),
    .hcount_out(a_hc), .hsync_out(a_hs), .hblnk_out(a_hb),
    .vcount_out(a_vc), .vsync_out(a_vs), .vblnk_out(a_vb),
    .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_b (
    .pclk(pclk), .rst(rst), .en(en),
    .hcount_out(b_hc), .hsync_out(b_hs), .hblnk_out(b_hb),
    .vcount_out(b_vc), .vsync_out(b_vs), .vblnk_out(b_vb),
    .frame_start(b_fs)
  );

  // Expected raster sample for linear position p (active-high sync convention).
  function automatic obs_t expect_of(input int p, input bit fs);
    obs_t o;
    int h, v;
    h    = p % HT;
    v    = p / HT;
    o.hc = 12'(h);
    o.vc = 12'(v);
    o.hb = (h >= HV);
    o.hs = (h >= HV + HF) && (h < HV + HF + HS);
    o.vb = (v >= VV);
    o.vs = (v >= VV + VF) && (v < VV + VF + VS);
    o.fs = fs;
    return o;
  endfunction

  // One clock: advance the model for this edge, queue the expected sample, then drive next inputs.
  task automatic cycle(input logic nrst, input logic nen);
    @(posedge pclk);
    if (!rst) begin
      pos  = 0;
      fs_m = 1'b0;
    end else if (en) begin
      pos  = (pos + 1) % FT;
      fs_m = (pos == 0);
    end else begin
      fs_m = 1'b0;
    end
    // Reset is asynchronous: it takes effect before the next sample.
    if (!nrst) begin
      pos  = 0;
      fs_m = 1'b0;
    end
    q.push_back(expect_of(pos, fs_m));
    #1;
    rst = nrst;
    en  = nen;
  endtask

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got hc=%0d vc=%0d hs=%b hb=%b vs=%b vb=%b fs=%b required hc=%0d vc=%0d hs=%b hb=%b vs=%b vb=%b fs=%b",
               name, cyc, got.hc, got.vc, got.hs, got.hb, got.vs, got.vb, got.fs,
               exp.hc, exp.vc, exp.hs, exp.hb, exp.vs, exp.vb, exp.fs);
    end
  endtask

  // Monitor: sample away from the active edge, pop one expectation per cycle.
  always @(negedge pclk) begin
    cyc++;
    if (q.size() != 0) begin
      mon_e  = q.pop_front();
      mon_eb = mon_e;
      mon_eb.hs = ~mon_e.hs;
      mon_eb.vs = ~mon_e.vs;
      mon_a = {a_hc, a_vc, a_hs, a_hb, a_vs, a_vb, a_fs};
      mon_b = {b_hc, b_vc, b_hs, b_hb, b_vs, b_vb, b_fs};
      check("pol_high", mon_a, mon_e);
      check("pol_low", mon_b, mon_eb);
    end
    if (!gap_chk) begin
      last_fs = -1;
    end else if (a_fs) begin
      if (last_fs >= 0) begin
        n_cmp++;
        if (cyc - last_fs != FT) begin
          n_fail++;
          $display("FAIL frame_gap got %0d cycles required %0d", cyc - last_fs, FT);
        end
      end
      last_fs = cyc;
    end
  end

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    pos  = 0;
    fs_m = 1'b0;

    // Held in reset.
    repeat (4) cycle(1'b0, 1'b0);
    // Release with en high; first counting edge gives hcount 1.
    cycle(1'b1, 1'b1);

    // Three-plus frames of continuous counting, checking frame_start spacing.
    gap_chk = 1'b1;
    repeat (3 * FT + 10) cycle(1'b1, 1'b1);
    gap_chk = 1'b0;

    // Stall for 10 edges right before the hsync window opens.
    for (int i = 0; i < FT && (pos % HT) != HV + HF - 2; i++) cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    repeat (9) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    repeat (5) cycle(1'b1, 1'b1);

    // Mid-line reset with en held high.
    repeat (7) cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b1);
    repeat (30) cycle(1'b1, 1'b1);

    // Randomised enable pattern with rare resets.
    repeat (3000) cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0));
    cycle(1'b1, 1'b1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge pclk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing source. It produces the hcount/vcount, sync and blanking stream that the downstream draw stages (background, rectangle/char overlay, image ROM readers) consume and pipeline forward. It sits at the head of the video chain in the pclk domain and drives the stage inputs directly. Default geometry is 800x600 @ 60 Hz with a 40 MHz pclk.

## Interface
Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BACK, 88, horizontal back porch (pixels); line total = 1056
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BACK, 23, vertical back porch (lines); frame total = 628
- HSYNC_POL, 1, active level of hsync
- VSYNC_POL, 1, active level of vsync

Ports:
- pclk  in  1  pixel clock; all logic on its rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  count enable; low freezes all outputs
- hcount_out  out  12  horizontal position, 0..1055
- hsync_out  out  1  horizontal sync
- hblnk_out  out  1  horizontal blanking
- vcount_out  out  12  vertical position, 0..627
- vsync_out  out  1  vertical sync
- vblnk_out  out  1  vertical blanking
- frame_start  out  1  one-cycle pulse when the raster is at (0,0)

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK. V_TOTAL is built the same way from the V_ parameters.
- **Horizontal counter:** increments by 1 on each en cycle. From H_TOTAL-1 it wraps to 0.
- **Vertical counter:** advances by 1 only on a cycle where hcount wraps. From V_TOTAL-1 it wraps to 0 on that same cycle, so (1055,627) is followed by (0,0).
- **hblnk:** high iff hcount ≥ H_VISIBLE, i.e. 800..1055.
- **hsync:** at HSYNC_POL iff H_VISIBLE+H_FRONT ≤ hcount < H_VISIBLE+H_FRONT+H_SYNC, i.e. 840..967. Otherwise it is at the inverse level.
- **vblnk:** high iff vcount ≥ V_VISIBLE, i.e. 600..627.
- **vsync:** at VSYNC_POL iff V_VISIBLE+V_FRONT ≤ vcount < that value + V_SYNC, i.e. 601..604.
- **frame_start:** high iff hcount==0 and vcount==0 and en was high on the cycle that produced that state.
- **Flags and count alignment:** every flag is decoded from the next-state count values and registered. Flags are therefore cycle-aligned with the hcount/vcount they describe, with no skew.
- **Widths:** all counters are 12 bit. Parameters must satisfy H_TOTAL, V_TOTAL ≤ 4096. This is enforced by an elaboration-time check.
- **en low:** all registers hold and frame_start is 0. Counting resumes from the held position.

## Timing
- **Reset values (asynchronous, while rst low):**
  - hcount_out = 0, vcount_out = 0
  - hblnk_out = 0, vblnk_out = 0
  - hsync_out = ~HSYNC_POL, vsync_out = ~VSYNC_POL
  - frame_start = 0
- **After reset release:**
  - The first rising edge with en high gives hcount_out = 1.
  - Position (0,0) after reset is not flagged by frame_start. The first pulse is at the first wrap to (0,0).
- **Output latency:** all outputs are registered with zero extra pipeline. Downstream stages see one coherent sample per cycle.
- **Period:** one line = 1056 cycles; one frame = 1056×628 = 663168 cycles. frame_start repeats at exactly that period while en is held high.
- **Reset mid-frame:** all outputs return immediately to the reset values, with no partial-line completion.

## Structure
- **Shared package vga_pkg:** default geometry constants (the H_/V_ values above, H_TOTAL, V_TOTAL) and the 12-bit count width. Draw stages share these constants.
- **Sub-module vga_axis_cnt:** parameterised by VISIBLE/FRONT/SYNC/BACK/POL, with inputs step/en and outputs count, blnk, sync, wrap. It is instantiated twice: horizontal with step=en, vertical with step=hwrap.
- **Top level:** generates frame_start.

## Test plan
- **Reset values:** assert rst low mid-line with en=1 -> outputs immediately 0/0, blanks 0, syncs inactive (hsync=vsync=0 with default polarity).
- **Horizontal flags:** release reset, en=1, and step through one line:
  - hblnk rises at hcount=800
  - hsync high for exactly hcount 840..967 (128 cycles)
  - hcount 1055 is followed by 0, with vcount incrementing on that same edge
- **Vertical flags:** run a full frame:
  - vblnk high for vcount 600..627
  - vsync high for vcount 601..604 (4×1056 cycles)
  - (1055,627) is followed by (0,0) with frame_start=1 for exactly one cycle
- **Frame period:** run 3 frames -> frame_start spacing is exactly 663168 cycles, and there is no pulse for the post-reset (0,0).
- **en stall:** drop en for 10 cycles at hcount=839 -> all outputs frozen. On resume the next value is hcount=840 with hsync asserting.
- **Polarity:** instantiate with HSYNC_POL=0, VSYNC_POL=0 -> syncs idle high and pulse low in the same windows; reset drives them high.
